clk_div_ctrl: RTL
=================

Name: clk_div_ctrl

Overview:
Run-time controller for a programmable toggle-type clock divider. It generates clk_out from clk with a programmable half-period, and provides a valid/ready configuration port and an enable-driven start/stop sequencer. Half-period changes and stops only take effect at glitch-free boundaries. It sits between the control logic and any logic clocked or enabled by the divided clock.

Parameters:
CNT_W, 26, width of the half-period counter and of cfg_half
DEFAULT_HALF, 24999999, half-period terminal count loaded at reset (must fit in CNT_W)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
en  input  1  run request: 1 = run divider, 0 = stop
cfg_valid  input  1  new half-period offered
cfg_half  input  CNT_W  half-period terminal count; high and low phases each last cfg_half+1 clk cycles
cfg_ready  output  1  controller can accept cfg_half
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse in the same cycle clk_out changes value
running  output  1  1 whenever state is not IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, count=0, clk_out=0, tick=0.
  - half_active=DEFAULT_HALF, pending=0, shadow=0, cfg_ready=1, running=0.
- All outputs are registered; cfg_ready = ~pending.
- Config handshake: a transfer occurs on a rising clk edge when cfg_valid & cfg_ready.
  - In IDLE: half_active <= cfg_half on the next edge; pending stays 0.
  - In RUN or STOPPING: shadow <= cfg_half and pending <= 1, so cfg_ready drops next cycle.
  - cfg_half=0 is legal and gives divide-by-2.
- Terminal count: "boundary" means count==half_active. At a boundary: count <= 0, clk_out <= ~clk_out, tick <= 1. Otherwise count <= count+1 and tick <= 0.
- Falling boundary: a boundary with clk_out==1. Only here is a pending update applied: half_active <= shadow, pending <= 0. The new value governs the following low phase, so full periods are never mixed.
- A transfer accepted in the same cycle as a falling boundary is applied at the next falling boundary.
- FSM:
  - IDLE: count held at 0, clk_out=0. If en=1, go to RUN next edge with count=0. The first rising toggle occurs half_active+1 cycles after entering RUN.
  - RUN: counts as above.
    - en=0 with clk_out=0: go to IDLE next edge with count <= 0. Low phase is truncated; no glitch.
    - en=0 with clk_out=1: go to STOPPING and keep counting.
  - STOPPING: counts as above. At the falling boundary, clk_out <= 0, tick pulses, any pending update is applied, and the state goes to IDLE. If en returns to 1 before that boundary, go back to RUN with no disturbance to count or clk_out.
- clk_out never produces a high or low phase shorter than half_active+1 cycles, except a truncated low phase at stop.
- Counter never exceeds half_active. Updates occur only with count=0, so there is no wrap-around hazard.
- Reset mid-operation: immediate return to reset values. The pending update is discarded.

Test Plan:
(Bench uses CNT_W=8, DEFAULT_HALF=3.)
1. Release reset, en=1 -> clk_out rises 4 cycles after running goes 1; period 8 cycles, 50% duty; tick coincides with every clk_out edge.
2. In IDLE, send cfg_half=0 then en=1 -> clk_out toggles every cycle (divide-by-2); cfg_ready stays 1.
3. RUN with half 3, send cfg_half=1 mid-high-phase -> cfg_ready=0 until the falling boundary; the current high phase is 4 cycles, then phases are 2 cycles; cfg_ready returns to 1.
4. cfg_valid held with value 5 while a pending update of 1 exists -> no accept until cfg_ready=1; then 5 is applied at the following falling boundary.
5. Drop en during the high phase -> high phase completes (4 cycles total), clk_out=0, running=0. Drop en during the low phase -> running=0 the next cycle, clk_out stays 0.
6. Assert rst while clk_out=1 and an update is pending -> clk_out=0, cfg_ready=1, running=0 immediately. After release with en=1, the period is 8 cycles (DEFAULT_HALF restored).

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Toggle-type clock divider with a valid/ready half-period config port and en-driven start/stop.
// All outputs are registered. cfg_ready drops for one buffered update until the next falling boundary.
module clk_div_ctrl #(
  parameter int          CNT_W        = 26,
  parameter int unsigned DEFAULT_HALF = 24999999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] half_active_q, half_active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;

  logic boundary;
  logic accept;
  logic counting;

  assign boundary = (count_q == half_active_q);
  assign accept   = cfg_valid & ~pending_q;

  // Stopping from a low phase truncates it; every other non-idle cycle advances the divider.
  assign counting = (state_q == STOPPING) ||
                    ((state_q == RUN) && (en || clk_out_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      half_active_q <= CNT_W'(DEFAULT_HALF);
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      half_active_q <= half_active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
      running_q     <= running_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          if (!clk_out_q || boundary) state_d = IDLE;
          else                        state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (en)            state_d = RUN;
        else if (boundary) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d       = count_q;
    clk_out_d     = clk_out_q;
    tick_d        = 1'b0;
    half_active_d = half_active_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    running_d     = (state_d != IDLE);

    if (counting) begin
      if (boundary) begin
        count_d   = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = 1'b1;
        // Buffered updates land only at the end of a high phase so a period is never mixed.
        if (clk_out_q && pending_q) begin
          half_active_d = shadow_q;
          pending_d     = 1'b0;
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else begin
      count_d   = '0;
      clk_out_d = 1'b0;
    end

    if (accept) begin
      if (state_q == IDLE) begin
        half_active_d = cfg_half;
      end else begin
        shadow_d  = cfg_half;
        pending_d = 1'b1;
      end
    end
  end

  assign cfg_ready = ~pending_q;
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign running   = running_q;

endmodule
